tart_clk_monitor: RTL and testbench
===================================

# tart_clk_monitor

Supervises the sampling-clock generator. Runs on the 6x fast clock (98.208 MHz) and consumes the generator's raw lock indication plus its 16.368 MHz reference, sampled as data. Produces a reset for downstream logic: asserted asynchronously, released synchronously, and released only after lock has been stable and the measured reference period matches the expected ratio. Also reports the measured period, lock-loss events and a saturating error count.

## Interface
- RATIO, 6: expected fast-clock cycles per reference period
- TOL, 0: allowed |period − RATIO|
- SETTLE, 16: cycles synchronized lock must stay high before checking; ≥1
- PW, 5: width of period counter; must hold 2*RATIO
- CNT_W, 8: width of err_count

- clk  in  1  fast clock, 98.208 MHz
- reset_n  in  1  asynchronous, active-low reset
- locked_in  in  1  raw generator lock, asynchronous to clk
- ref_in  in  1  16.368 MHz reference, treated as asynchronous data
- clear  in  1  synchronous; zeroes err_count
- rst_out_n  out  1  downstream reset, active-low
- clk_ok  out  1  last measured period in tolerance (RUN only)
- period  out  PW  last measured period in clk cycles
- lock_lost  out  1  one-cycle pulse on lock loss
- err_count  out  CNT_W  saturating error count

## Operation
- Two-flop synchronizers on locked_in → lock_s and ref_in → ref_s. A third flop ref_d drives rise = ref_s & ~ref_d.
- Period counter pcnt:
  - on rise: period ← pcnt, pcnt ← 1
  - otherwise pcnt ← pcnt+1, saturating at 2*RATIO
  - timeout event: the cycle pcnt becomes 2*RATIO; fires once per stall
- A measurement is valid only on a rise with have_edge=1. have_edge is set by any rise and cleared on entry to CHECK.
- good = valid & (|period_new − RATIO| ≤ TOL). bad = (valid & !good) | timeout.
- States: WAIT_LOCK, SETTLE, CHECK, RUN.
  - WAIT_LOCK: → SETTLE when lock_s=1; load settle counter to 0.
  - SETTLE: counter increments each cycle; → CHECK when the counter reaches SETTLE−1 with lock_s=1.
  - CHECK: a run of 2 consecutive good measurements → RUN. A bad event resets the run count to 0.
  - RUN: good → clk_ok=1. bad → clk_ok=0 and err_count+1. Stays in RUN.
  - From SETTLE, CHECK or RUN, lock_s=0 → WAIT_LOCK, lock_lost pulse, err_count+1. This takes priority over any same-cycle measurement.
- Outputs by state:
  - rst_out_n = 1 only in RUN, registered.
  - clk_ok = 0 outside RUN.
- err_count:
  - saturates at all-ones
  - clear has priority over a same-cycle increment (result 0)
  - not cleared by lock loss
- Reset (reset_n=0), all immediate and asynchronous:
  - state ← WAIT_LOCK
  - rst_out_n, clk_ok, lock_lost ← 0
  - period, err_count ← 0
  - pcnt, synchronizers, have_edge ← 0

## Timing
- locked_in rise to lock_s: 2 cycles.
- lock_s high to CHECK entry: SETTLE cycles.
- CHECK to RUN (ideal reference):
  - first rise after CHECK entry arms have_edge
  - two further rises give two good periods
  - RUN entered on the cycle after the second good rise
  - rst_out_n=1 in that same first RUN cycle
- Worst case lock_s to rst_out_n: SETTLE + 3*RATIO + 1 cycles.
- Lock loss: rst_out_n=0 and lock_lost=1 in the cycle after lock_s falls (locked_in fall + 3). lock_lost is 0 the following cycle.
- Registered outputs update the cycle after the causing event:
  - period: the cycle after rise
  - clk_ok: the cycle after the measurement
  - err_count: the cycle after the event
- Lock glitch shorter than 2 cycles may be missed; this is acceptable.

## Test plan
- Reset, then locked_in=1 and ref_in at clk/6 (3 high, 3 low). Required:
  - rst_out_n rises within SETTLE+2+19 cycles
  - period=6, clk_ok=1
  - err_count=0, lock_lost never 1
- In RUN, stretch one ref_in period to 8 cycles. Required:
  - period=8, clk_ok=0, err_count=1
  - next normal period: period=6, clk_ok=1
  - rst_out_n stays 1 throughout
- In RUN, hold ref_in low. Required:
  - timeout at pcnt=12
  - err_count increments exactly once, clk_ok=0
  - on resume, period latches 12, then 6
- In RUN, drop locked_in for 10 cycles. Required:
  - rst_out_n=0 and single-cycle lock_lost 3 cycles after the fall
  - err_count+1
  - re-release only after SETTLE + two good periods
- Drive err_count to 255 with repeated bad periods, then more bad periods; 255 must hold. Assert clear on the same cycle as a bad event; err_count must become 0.
- Pulse reset_n low mid-CHECK. Required:
  - all outputs are 0 immediately, asynchronously
  - after release, the sequence restarts from WAIT_LOCK

Source files
------------

// File: rtl/tart_clk_monitor.sv
// tart_clk_monitor
//   Supervises the sampling-clock generator from the 6x fast clock. Lock and
//   the reference clock are both sampled as asynchronous data. Downstream reset
//   is released only after lock has settled and two consecutive reference
//   periods measure at RATIO (+/- TOL) fast cycles.
//
// Ports
//   clk        fast clock (98.208 MHz)
//   reset_n    asynchronous active-low reset
//   locked_in  raw generator lock (async)
//   ref_in     16.368 MHz reference (async data)
//   clear      synchronous clear of err_count
//   rst_out_n  downstream reset, active-low, high only in RUN
//   clk_ok     last measured period in tolerance (RUN only)
//   period     last measured period in clk cycles
//   lock_lost  one-cycle pulse on lock loss
//   err_count  saturating error count
module tart_clk_monitor #(
  parameter int RATIO  = 6,
  parameter int TOL    = 0,
  parameter int SETTLE = 16,
  parameter int PW     = 5,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             locked_in,
  input  logic             ref_in,
  input  logic             clear,
  output logic             rst_out_n,
  output logic             clk_ok,
  output logic [PW-1:0]    period,
  output logic             lock_lost,
  output logic [CNT_W-1:0] err_count
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [PW-1:0] PMAX  = PW'(2 * RATIO);
  localparam logic [PW-1:0] PNOM  = PW'(RATIO);
  localparam logic [PW-1:0] PTOL  = PW'(TOL);
  localparam logic [SW-1:0] SLAST = SW'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK,
    ST_SETTLE,
    ST_CHECK,
    ST_RUN
  } state_t;

  state_t state, state_nx;

  logic lock_meta, lock_s;
  logic ref_meta, ref_s, ref_d;
  logic [PW-1:0] pcnt;
  logic have_edge;
  logic [SW-1:0] scnt, scnt_nx;
  logic run_cnt, run_cnt_nx;
  logic ok_nx, lost_nx, inc;

  logic rise, timeout, valid, in_tol, good, bad, chk_entry;
  logic [PW-1:0] dev;

  // Synchronizers; ref_d is the extra stage for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      ref_meta  <= 1'b0;
      ref_s     <= 1'b0;
      ref_d     <= 1'b0;
    end else begin
      lock_meta <= locked_in;
      lock_s    <= lock_meta;
      ref_meta  <= ref_in;
      ref_s     <= ref_meta;
      ref_d     <= ref_s;
    end
  end

  assign rise = ref_s & ~ref_d;

  // Timeout is the cycle pcnt steps onto its saturation value, so it fires
  // once per stall rather than every cycle while saturated.
  assign timeout = ~rise & (pcnt == PMAX - PW'(1));

  assign dev       = (pcnt > PNOM) ? (pcnt - PNOM) : (PNOM - pcnt);
  assign in_tol    = (dev <= PTOL);
  assign valid     = rise & have_edge;
  assign good      = valid & in_tol;
  assign bad       = (valid & ~in_tol) | timeout;
  assign chk_entry = (state_nx == ST_CHECK) && (state != ST_CHECK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt      <= '0;
      period    <= '0;
      have_edge <= 1'b0;
    end else begin
      if (rise) begin
        period <= pcnt;
        pcnt   <= PW'(1);
      end else if (pcnt != PMAX) begin
        pcnt <= pcnt + PW'(1);
      end
      // The first rise after CHECK entry only re-arms; the partial period
      // leading up to it is never trusted.
      if (chk_entry)  have_edge <= 1'b0;
      else if (rise)  have_edge <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_WAIT_LOCK;
      scnt      <= '0;
      run_cnt   <= 1'b0;
      rst_out_n <= 1'b0;
      clk_ok    <= 1'b0;
      lock_lost <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nx;
      scnt      <= scnt_nx;
      run_cnt   <= run_cnt_nx;
      rst_out_n <= (state_nx == ST_RUN);
      clk_ok    <= ok_nx;
      lock_lost <= lost_nx;
      if (clear)                       err_count <= '0;
      else if (inc && (err_count != '1)) err_count <= err_count + CNT_W'(1);
    end
  end

  always_comb begin
    state_nx   = state;
    scnt_nx    = scnt;
    run_cnt_nx = run_cnt;
    ok_nx      = clk_ok;
    lost_nx    = 1'b0;
    inc        = 1'b0;
    case (state)
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_nx = ST_SETTLE;
          scnt_nx  = '0;
        end
      end
      ST_SETTLE: begin
        if (!lock_s) begin
          state_nx = ST_WAIT_LOCK;
          lost_nx  = 1'b1;
          inc      = 1'b1;
        end else if (scnt == SLAST) begin
          state_nx   = ST_CHECK;
          run_cnt_nx = 1'b0;
        end else begin
          scnt_nx = scnt + SW'(1);
        end
      end
      ST_CHECK: begin
        if (!lock_s) begin
          state_nx = ST_WAIT_LOCK;
          lost_nx  = 1'b1;
          inc      = 1'b1;
        end else if (bad) begin
          run_cnt_nx = 1'b0;
        end else if (good) begin
          if (run_cnt) state_nx = ST_RUN;
          run_cnt_nx = 1'b1;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_nx = ST_WAIT_LOCK;
          lost_nx  = 1'b1;
          inc      = 1'b1;
        end else if (good) begin
          ok_nx = 1'b1;
        end else if (bad) begin
          ok_nx = 1'b0;
          inc   = 1'b1;
        end
      end
      default: state_nx = ST_WAIT_LOCK;
    endcase
    if (state_nx != ST_RUN) ok_nx = 1'b0;
  end

endmodule

// File: tb/tb_tart_clk_monitor.sv
module tb_tart_clk_monitor;

  logic       clk = 1'b0;
  logic       reset_n, locked_in, ref_in, clear;
  logic       rst_out_n, clk_ok, lock_lost;
  logic [4:0] period;
  logic [7:0] err_count;

  int errors = 0;
  int checks = 0;
  int lost_seen = 0;

  tart_clk_monitor #(.RATIO(6), .TOL(0), .SETTLE(16), .PW(5), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .locked_in(locked_in), .ref_in(ref_in),
    .clear(clear), .rst_out_n(rst_out_n), .clk_ok(clk_ok), .period(period),
    .lock_lost(lock_lost), .err_count(err_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (lock_lost === 1'b1) lost_seen++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  typedef struct {
    int   len;
    int   clr;
    logic exp_rst;
    logic exp_ok;
    int   exp_per;
    int   exp_err;
  } vec_t;

  vec_t tbl[9];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One reference period: 3 high, len-3 low; clear asserted in cycle clr.
  task automatic run_period(input int len, input int clr);
    for (int i = 0; i < len; i++) begin
      ref_in = (i < 3);
      clear  = (i == clr);
      tick(1);
    end
    clear = 1'b0;
  endtask

  // Relock from scratch with ideal reference; release expected after 6 periods.
  task automatic bring_up(input string tag, input int exp_err);
    for (int p = 1; p <= 6; p++) begin
      run_period(6, -1);
      if (p == 5) chk({tag, "_rst_low_p5"}, int'(rst_out_n), 0);
    end
    chk({tag, "_rst_high_p6"}, int'(rst_out_n), 1);
    chk({tag, "_period"}, int'(period), 6);
    chk({tag, "_err"}, int'(err_count), exp_err);
  endtask

  initial begin
    tbl[0] = '{6, -1, 1'b1, 1'b1, 6, 0};
    tbl[1] = '{8, -1, 1'b1, 1'b1, 6, 0};
    tbl[2] = '{6, -1, 1'b1, 1'b0, 8, 1};
    tbl[3] = '{6, -1, 1'b1, 1'b1, 6, 1};
    tbl[4] = '{6,  0, 1'b1, 1'b1, 6, 0};
    tbl[5] = '{7, -1, 1'b1, 1'b1, 6, 0};
    tbl[6] = '{5, -1, 1'b1, 1'b0, 7, 1};
    tbl[7] = '{6, -1, 1'b1, 1'b0, 5, 2};
    tbl[8] = '{6, -1, 1'b1, 1'b1, 6, 2};

    reset_n = 1'b0; locked_in = 1'b0; ref_in = 1'b0; clear = 1'b0;
    tick(3);
    chk("rst_rst_out_n", int'(rst_out_n), 0);
    chk("rst_clk_ok", int'(clk_ok), 0);
    chk("rst_lock_lost", int'(lock_lost), 0);
    chk("rst_period", int'(period), 0);
    chk("rst_err", int'(err_count), 0);
    reset_n = 1'b1;
    tick(3);

    // Bring-up: release 33 cycles after locked_in, seen at the 36-cycle sample.
    locked_in = 1'b1;
    bring_up("bringup", 0);
    run_period(6, -1);
    chk("bringup_clk_ok", int'(clk_ok), 1);
    chk("bringup_no_lock_lost", lost_seen, 0);

    // Each row's rise measures the previous row's length.
    for (int r = 0; r < 9; r++) begin
      run_period(tbl[r].len, tbl[r].clr);
      chk($sformatf("row%0d_rst", r), int'(rst_out_n), int'(tbl[r].exp_rst));
      chk($sformatf("row%0d_ok", r), int'(clk_ok), int'(tbl[r].exp_ok));
      chk($sformatf("row%0d_period", r), int'(period), tbl[r].exp_per);
      chk($sformatf("row%0d_err", r), int'(err_count), tbl[r].exp_err);
    end

    // Reference stall: one timeout error, then the 12-cycle period on resume.
    tick(20);
    chk("stall_err", int'(err_count), 3);
    chk("stall_ok", int'(clk_ok), 0);
    chk("stall_period", int'(period), 6);
    tick(10);
    chk("stall_err_once", int'(err_count), 3);
    run_period(6, -1);
    chk("resume_period12", int'(period), 12);
    chk("resume_err", int'(err_count), 4);
    chk("resume_ok0", int'(clk_ok), 0);
    run_period(6, -1);
    chk("resume_period6", int'(period), 6);
    chk("resume_ok1", int'(clk_ok), 1);
    chk("stall_rst_held", int'(rst_out_n), 1);

    // Lock loss for 10 cycles.
    locked_in = 1'b0;
    tick(1);
    chk("ll_c1_lost", int'(lock_lost), 0);
    chk("ll_c1_rst", int'(rst_out_n), 1);
    tick(1);
    chk("ll_c2_lost", int'(lock_lost), 0);
    chk("ll_c2_rst", int'(rst_out_n), 1);
    tick(1);
    chk("ll_c3_lost", int'(lock_lost), 1);
    chk("ll_c3_rst", int'(rst_out_n), 0);
    chk("ll_c3_ok", int'(clk_ok), 0);
    chk("ll_c3_err", int'(err_count), 5);
    tick(1);
    chk("ll_c4_lost", int'(lock_lost), 0);
    tick(6);
    locked_in = 1'b1;
    bring_up("relock", 5);
    chk("relock_lost_count", lost_seen, 1);

    // Saturation with 7-cycle periods.
    for (int k = 0; k < 300 && err_count != 8'hFF; k++) run_period(7, -1);
    chk("sat_reach", int'(err_count), 255);
    repeat (3) run_period(7, -1);
    chk("sat_hold", int'(err_count), 255);
    chk("sat_ok", int'(clk_ok), 0);
    // Clear in the same cycle as the bad measurement of the last 7-cycle period.
    run_period(6, 2);
    chk("clear_vs_inc", int'(err_count), 0);
    chk("clear_period", int'(period), 7);
    run_period(6, -1);
    chk("post_clear_ok", int'(clk_ok), 1);
    chk("post_clear_err", int'(err_count), 0);

    // Drop lock, relock, and hit reset mid-CHECK.
    locked_in = 1'b0;
    tick(10);
    locked_in = 1'b1;
    repeat (4) run_period(6, -1);
    chk("precheck_err", int'(err_count), 1);
    chk("precheck_period", int'(period), 6);
    chk("precheck_rst", int'(rst_out_n), 0);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_out_n", int'(rst_out_n), 0);
    chk("async_clk_ok", int'(clk_ok), 0);
    chk("async_lock_lost", int'(lock_lost), 0);
    chk("async_period", int'(period), 0);
    chk("async_err", int'(err_count), 0);
    tick(2);
    chk("held_rst_period", int'(period), 0);
    reset_n = 1'b1;
    bring_up("restart", 0);
    chk("final_lost_count", lost_seen, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
